// File: rtl/iiitb_fifo.sv
//==============================================================================
// Module   : iiitb_fifo
// Brief    : 16 x 8 synchronous single-clock FIFO with first-word-fall-through
//            read port. Status outputs are empty, full, threshold, overflow
//            and underflow.
// Options  : FIFO_STICKY_ERR_EN - when defined, overflow/underflow are sticky
//            until their clearing event. When undefined, each flag is a
//            one-cycle registered pulse.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module iiitb_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int THRESHOLD  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_threshold,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam int                c_DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH + 1)'(c_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_THRESH    = (ADDR_WIDTH + 1)'(THRESHOLD);
    localparam logic [ADDR_WIDTH:0] c_ONE       = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_en;
    logic                  w_rd_en;

    // Pointer MSBs only track wrap parity; storage is addressed by the low bits.
    logic                  w_unused_ptr_msb;
    assign w_unused_ptr_msb = r_wr_ptr[ADDR_WIDTH] ^ r_rd_ptr[ADDR_WIDTH];

    // Acceptance is gated by the registered status, so a full FIFO rejects a
    // write even when a read frees a slot on the same edge.
    assign w_wr_en = wr & ~fifo_full;
    assign w_rd_en = rd & ~fifo_empty;

    assign fifo_full      = (r_count == c_DEPTH_CNT);
    assign fifo_empty     = (r_count == '0);
    assign fifo_threshold = (r_count >= c_THRESH);
    assign fifo_overflow  = r_overflow;
    assign fifo_underflow = r_underflow;

    // Fall-through head: the word at the read pointer is always visible.
    assign data_out = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];

    // Storage: cleared on reset so data_out reads zero until the first write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // Pointers and occupancy advance only on accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_ONE;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Error flags: a new offending request takes priority over a clear on the
    // same edge, so the event is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            if (wr && fifo_full) begin
                r_overflow <= 1'b1;
            end else if (w_rd_en) begin
                r_overflow <= 1'b0;
            end
            if (rd && fifo_empty) begin
                r_underflow <= 1'b1;
            end else if (w_wr_en) begin
                r_underflow <= 1'b0;
            end
`else
            r_overflow  <= wr & fifo_full;
            r_underflow <= rd & fifo_empty;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_iiitb_fifo.sv
//==============================================================================
// Module   : tb_iiitb_fifo
// Brief    : Self-checking bench for iiitb_fifo. A queue-based reference model
//            is compared against the DUT every cycle, and directed sequences
//            pin literal expectations at the key boundaries.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_iiitb_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_threshold;
    logic       fifo_overflow;
    logic       fifo_underflow;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    iiitb_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4),
        .THRESHOLD (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr            (wr),
        .rd            (rd),
        .data_in       (data_in),
        .data_out      (data_out),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_threshold(fifo_threshold),
        .fifo_overflow (fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain byte queue plus error-flag rules.
    byte unsigned q[$];
    bit m_ovf     = 1'b0;
    bit m_udf     = 1'b0;
    bit m_written = 1'b0;
    bit m_full_now;
    bit m_empty_now;
    bit m_acc_w;
    bit m_acc_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
            m_written = 1'b0;
        end else begin
            m_full_now  = (q.size() == 16);
            m_empty_now = (q.size() == 0);
            m_acc_w     = wr && !m_full_now;
            m_acc_r     = rd && !m_empty_now;
`ifdef FIFO_STICKY_ERR_EN
            if (wr && m_full_now) m_ovf = 1'b1;
            else if (m_acc_r)     m_ovf = 1'b0;
            if (rd && m_empty_now) m_udf = 1'b1;
            else if (m_acc_w)      m_udf = 1'b0;
`else
            m_ovf = wr && m_full_now;
            m_udf = rd && m_empty_now;
`endif
            if (m_acc_r) void'(q.pop_front());
            if (m_acc_w) begin
                q.push_back(data_in);
                m_written = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_empty", int'(fifo_empty), int'(q.size() == 0));
            chk("cyc_full", int'(fifo_full), int'(q.size() == 16));
            chk("cyc_threshold", int'(fifo_threshold), int'(q.size() >= 8));
            chk("cyc_overflow", int'(fifo_overflow), int'(m_ovf));
            chk("cyc_underflow", int'(fifo_underflow), int'(m_udf));
            if (q.size() != 0)
                chk("cyc_data_out", int'(data_out), int'(q[0]));
            else if (!m_written)
                chk("cyc_data_out_rst", int'(data_out), 0);
        end
    end

    // One request cycle: inputs settle 1ns after a rising edge and are
    // released 1ns after the next one, where outputs are then sampled.
    task automatic cyc(input bit w, input bit r, input logic [7:0] d);
        wr      = w;
        rd      = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    logic [7:0] wv;

    initial begin
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_full", int'(fifo_full), 0);
        chk("rst_data_out", int'(data_out), 0);
        rst_n = 1'b1;
        cyc(0, 0, 8'h00);
        chk("idle_empty", int'(fifo_empty), 1);
        chk("idle_threshold", int'(fifo_threshold), 0);
        chk("idle_ovf", int'(fifo_overflow), 0);
        chk("idle_udf", int'(fifo_underflow), 0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 8'(i));
            if (i == 1) begin
                chk("fill1_empty", int'(fifo_empty), 0);
                chk("fill1_data_out", int'(data_out), 8'h01);
            end
            if (i == 7)  chk("fill7_threshold", int'(fifo_threshold), 0);
            if (i == 8)  chk("fill8_threshold", int'(fifo_threshold), 1);
            if (i == 15) chk("fill15_full", int'(fifo_full), 0);
            if (i == 16) chk("fill16_full", int'(fifo_full), 1);
        end
        chk("model_size_full", q.size(), 16);

        // Overflow attempt
        cyc(1, 0, 8'h11);
        chk("ovf_flag", int'(fifo_overflow), 1);
        chk("ovf_full", int'(fifo_full), 1);
        chk("ovf_head", int'(data_out), 8'h01);
        chk("model_size_ovf", q.size(), 16);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            chk("drain_head", int'(data_out), i);
            cyc(0, 1, 8'h00);
            if (i == 1) chk("drain1_ovf_clear", int'(fifo_overflow), 0);
            if (i == 8) chk("drain8_threshold", int'(fifo_threshold), 1);
            if (i == 9) chk("drain9_threshold", int'(fifo_threshold), 0);
            if (i == 15) chk("drain15_empty", int'(fifo_empty), 0);
        end
        chk("drained_empty", int'(fifo_empty), 1);

        // Underflow, consecutive, then cleared by a write
        cyc(0, 1, 8'h00);
        chk("udf_flag1", int'(fifo_underflow), 1);
        cyc(0, 1, 8'h00);
        chk("udf_flag2", int'(fifo_underflow), 1);
        chk("udf_empty", int'(fifo_empty), 1);
        cyc(1, 0, 8'hAA);
        chk("udf_clear", int'(fifo_underflow), 0);
        chk("udf_wr_data", int'(data_out), 8'hAA);
        cyc(0, 1, 8'h00);
        chk("aa_read_empty", int'(fifo_empty), 1);

        // Simultaneous rd&wr at count 0: write accepted, read rejected
        cyc(1, 1, 8'h55);
        chk("rw0_empty", int'(fifo_empty), 0);
        chk("rw0_data", int'(data_out), 8'h55);
        chk("rw0_udf", int'(fifo_underflow), 1);
        chk("model_size_rw0", q.size(), 1);

        // Build to 8, then simultaneous rd&wr at count 8
        wv = 8'h60;
        for (int i = 0; i < 7; i++) begin
            cyc(1, 0, wv);
            wv = wv + 8'h01;
        end
        chk("pre8_threshold", int'(fifo_threshold), 1);
        cyc(1, 1, wv);
        wv = wv + 8'h01;
        chk("rw8_threshold", int'(fifo_threshold), 1);
        chk("rw8_head", int'(data_out), 8'h60);
        chk("model_size_rw8", q.size(), 8);

        // Build to 16, then simultaneous rd&wr at count 16
        for (int i = 0; i < 8; i++) begin
            cyc(1, 0, wv);
            wv = wv + 8'h01;
        end
        chk("pre16_full", int'(fifo_full), 1);
        cyc(1, 1, wv);
        wv = wv + 8'h01;
        chk("rw16_full", int'(fifo_full), 0);
        chk("rw16_ovf", int'(fifo_overflow), 1);
        chk("rw16_head", int'(data_out), 8'h61);
        chk("model_size_rw16", q.size(), 15);

        // Interleaved traffic across pointer wrap
        for (int k = 0; k < 20; k++) begin
            cyc(k % 3 != 2, k % 2 == 0, wv);
            wv = wv + 8'h01;
        end
        for (int k = 0; k < 20; k++) begin
            cyc(0, 1, 8'h00);
        end
        chk("wrap_drained_empty", int'(fifo_empty), 1);

        // Asynchronous reset mid-stream
        cyc(1, 0, 8'hA1);
        cyc(1, 0, 8'hA2);
        cyc(1, 0, 8'hA3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_empty", int'(fifo_empty), 1);
        chk("arst_full", int'(fifo_full), 0);
        chk("arst_data_out", int'(data_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 0, 8'hB0);
        chk("post_rst_data", int'(data_out), 8'hB0);
        chk("post_rst_empty", int'(fifo_empty), 0);
        cyc(0, 0, 8'h00);
        cyc(0, 0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/iiitb_fifo.md
Name: iiitb_fifo

Overview:
- Synchronous single-clock FIFO: 16 entries of 8-bit data, first-word-fall-through read port.
- Status outputs: empty, full, threshold (half-full), overflow error, underflow error.
- Used as a generic byte buffer between a producer (wr/data_in) and a consumer (rd/data_out) in the same clock domain.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out and each storage word
- ADDR_WIDTH, 4, pointer index width; depth = 2**ADDR_WIDTH = 16
- THRESHOLD, 8, fifo_threshold asserts when occupancy >= THRESHOLD

Ports:
- clk  in  1  rising-edge clock for all state
- rst_n  in  1  reset
- wr  in  1  write request, sampled at posedge clk
- rd  in  1  read request, sampled at posedge clk
- data_in  in  DATA_WIDTH  write data, captured with an accepted write
- data_out  out  DATA_WIDTH  head-of-queue word, combinational from storage at the read pointer
- fifo_full  out  1  occupancy == 16
- fifo_empty  out  1  occupancy == 0
- fifo_threshold  out  1  occupancy >= THRESHOLD
- fifo_overflow  out  1  write attempted while full
- fifo_underflow  out  1  read attempted while empty

Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- State:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide.
  - Occupancy count is ADDR_WIDTH+1 bits, range 0..16.
  - 16x8 storage array.
- Reset (rst_n low, asynchronous):
  - Pointers, count and all storage words clear to 0.
  - fifo_empty=1, fifo_full=0, fifo_threshold=0, fifo_overflow=0, fifo_underflow=0, data_out=0.
  - Reset asserted mid-operation discards all contents immediately.
- Accepted write: wr & ~fifo_full.
  - mem[wr_ptr[3:0]] <= data_in; wr_ptr increments.
- Accepted read: rd & ~fifo_empty.
  - rd_ptr increments; data_out shows the next entry after the edge.
- Read latency: zero (first-word fall-through).
  - data_out always equals mem[rd_ptr[3:0]].
  - When rd is sampled, data_out already holds the word being consumed.
  - The first written word appears on data_out the cycle after its write edge.
- Count update:
  - +1 on write only, -1 on read only.
  - Unchanged when both or neither are accepted.
- Simultaneous rd & wr:
  - Each is accepted independently per the rules above.
  - When full, the write is rejected even if a read is accepted the same cycle.
  - When empty, the read is rejected and the write is accepted.
- Flags fifo_full, fifo_empty, fifo_threshold: combinational decodes of the registered count.
- Pointer wrap: pointers wrap modulo 32; storage indexed by the low 4 bits. No data corruption across wrap.
- Rejected operations: no change to pointers, count or storage.
- fifo_overflow:
  - Set at posedge when wr & fifo_full.
  - Cleared at the next accepted read.
- fifo_underflow:
  - Set at posedge when rd & fifo_empty.
  - Cleared at the next accepted write.
- Error-flag timing under FIFO_STICKY_ERR_EN is defined in Optional Feature.

Optional Feature:
- Macro FIFO_STICKY_ERR_EN.
- Defined:
  - fifo_overflow and fifo_underflow are sticky registers.
  - Each holds until its clearing event (accepted read / accepted write) or reset.
- Undefined:
  - Each flag is a registered one-cycle pulse, high only in the cycle after the offending request edge.
  - Consecutive offending requests give consecutive high cycles.

Test Plan:
- Reset then idle:
  - rst_n low then high, no requests -> empty=1, full=0, threshold=0, overflow=0, underflow=0, data_out=0.
- Fill:
  - Write 0x01..0x10 with one write per request pulse -> threshold rises after the 8th write; full=1 after the 16th; empty=0 after the first.
  - data_out=0x01 from the cycle after the first write.
- Overflow:
  - 17th write of 0x11 while full -> rejected; overflow=1; contents unchanged; count stays 16.
- Drain and check order:
  - 16 reads -> data_out sampled at each read edge equals 0x01..0x10 in order.
  - Overflow clears on the first read (sticky build).
  - Threshold drops when count reaches 7; empty=1 after the 16th read.
- Underflow:
  - 17th read while empty -> underflow=1; pointers unchanged.
  - A following write of 0xAA clears underflow; data_out=0xAA.
- Wrap and concurrency:
  - 40 writes interleaved with reads, including simultaneous rd&wr at counts 0, 8 and 16 -> count follows the acceptance rules.
  - Read order matches write order across pointer wrap.
  - Asynchronous rst_n mid-stream clears everything immediately.
